addr_map_cfg_ctrl: RTL and testbench
====================================

// Module: addr_map_cfg_ctrl
// PURPOSE
//  Runtime configuration controller for the address decoder rule table.
//  - Holds a shadow rule table written rule-by-rule over a valid/ready port.
//  - On commit: validates every shadow rule, drains in-flight decodes via a
//    req/ack handshake, then swaps shadow into the active table in one cycle.
//  - Drives addr_map_o and config_ongoing_o of addr_decode_dync.
// PARAMETERS
//  NoIndices  32'd0  number of decoder targets; a rule idx must be < NoIndices
//  NoRules    32'd0  number of rules in the table (>=1)
//  addr_t     logic  address type
//  rule_t     logic  packed struct {int unsigned idx; addr_t start_addr; addr_t end_addr;}
//  Napot      1'b0   1: rules are base/mask, so the start/end range check is skipped
//  DefaultMap '0     rule_t [NoRules-1:0] loaded into shadow and active tables at reset
//  SelWidth   cf_math_pkg::idx_width(NoRules)  derived, do not override
// PORTS
//  clk_i            in  1           clock
//  rst_ni           in  1           asynchronous reset, active low
//  wr_valid_i       in  1           rule write request
//  wr_ready_o       out 1           rule write accepted when wr_valid_i && wr_ready_o
//  wr_sel_i         in  SelWidth    shadow slot to write
//  wr_rule_i        in  rule_t      rule data
//  commit_valid_i   in  1           commit request
//  commit_ready_o   out 1           commit accepted when both high
//  commit_done_o    out 1           1-cycle pulse: swap performed
//  commit_err_o     out 1           1-cycle pulse: validation failed, no swap
//  err_sel_o        out SelWidth    lowest failing slot, held until the next commit
//  drain_req_o      out 1           request downstream to quiesce decodes
//  drain_ack_i      in  1           downstream is quiescent
//  config_ongoing_o out 1           connects to addr_decode_dync.config_ongoing_i
//  addr_map_o       out rule_t[NoRules] active rule table
// BEHAVIOUR
//  - Reset values: shadow = active = DefaultMap; state IDLE; all pulses 0;
//    err_sel_o = 0; drain_req_o = 0; config_ongoing_o = 0.
//  - Reset may occur in any state and aborts the operation. The table returns
//    to DefaultMap and no commit_done_o is issued.
//  - FSM states and transitions:
//    - IDLE: wr_ready_o = 1.
//      - An accepted write updates shadow[wr_sel_i] at the clock edge.
//      - A write with wr_sel_i >= NoRules is accepted and dropped.
//      - commit_ready_o = !wr_valid_i, so a write wins a same-cycle commit.
//      - An accepted commit clears the check counter and enters CHECK.
//    - CHECK: checks one slot per cycle, counter 0..NoRules-1, for NoRules cycles.
//      - A slot fails if idx >= NoIndices.
//      - If !Napot, a slot also fails if end_addr != 0 && start_addr >= end_addr.
//      - All slots are scanned. The first failure latches err_sel_o.
//      - After the last slot: if any failure, pulse commit_err_o and go to IDLE.
//        Otherwise go to QUIESCE.
//    - QUIESCE: drain_req_o = 1 and config_ongoing_o = 1.
//      - Go to SWAP in the cycle drain_ack_i = 1. An ack already high on entry
//        counts, giving a minimum of 1 cycle.
//    - SWAP: config_ongoing_o = 1, drain_req_o = 0, commit_done_o = 1.
//      - active <= shadow at the end of this cycle, then go to IDLE.
//      - addr_map_o shows the new table from the next cycle on.
//  - Writes and commits are not accepted outside IDLE; wr_ready_o and
//    commit_ready_o are 0.
//  - Latency: commit handshake in cycle t; commit_done_o in cycle
//    t + NoRules + 2 (with drain_ack_i high); new addr_map_o in t + NoRules + 3.
//  - The active table never changes except in SWAP. A failed commit leaves
//    the shadow table intact so it can be corrected.
//  - commit_done_o and commit_err_o are never high in the same cycle.
//  - Assertions: NoRules >= 1; no valid signal drops before its handshake
//    (wr_valid_i, commit_valid_i).
// STRUCTURE
//  - Package addr_map_cfg_pkg:
//    - state_e enum {IDLE, CHECK, QUIESCE, SWAP};
//    - function rule_ok(rule, NoIndices, Napot).
//  - Sub-module addr_rule_check: combinational single-rule validator used by
//    CHECK through a shadow-slot mux.
//  - Shadow and active tables are flip-flop arrays. No memory macros.
// TESTING  (NoRules=4, NoIndices=3, addr_t=logic[31:0])
//  1. Reset -> addr_map_o == DefaultMap; wr_ready_o=1; config_ongoing_o=0;
//     no pulses.
//  2. Write slot0={1,0x1000,0x2000}, commit, drain_ack_i tied 1 ->
//     commit_done_o in cycle t+6, addr_map_o[0] updated in t+7,
//     config_ongoing_o high for exactly 2 cycles.
//  3. Write slot2={3,0x0,0x100} (idx>=3), slot3={0,0x500,0x400}, commit ->
//     commit_err_o pulse at t+5, err_sel_o=2, addr_map_o unchanged,
//     drain_req_o never high.
//  4. Commit with drain_ack_i held 0 for 10 cycles -> stays in QUIESCE,
//     drain_req_o=1, no writes accepted; ack -> SWAP next cycle.
//  5. Same-cycle wr_valid_i and commit_valid_i in IDLE -> write taken,
//     commit_ready_o=0; commit accepted the next cycle with the new data.
//  6. rst_ni low during QUIESCE -> async clear to IDLE, map == DefaultMap,
//     no commit_done_o; Napot=1 run: start_addr >= end_addr rule passes.

Source files
------------

// File: rtl/addr_map_cfg_pkg.sv
// Shared types and the single-rule validity function for the address-map
// configuration controller.
package addr_map_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      QUIESCE = 2'd2,
      SWAP    = 2'd3
   } state_e;

   localparam int unsigned MaxAddrWidth = 32'd64;

   typedef logic [31:0] default_addr_t;

   typedef struct packed {
      int unsigned   idx;
      default_addr_t start_addr;
      default_addr_t end_addr;
   } default_rule_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? $unsigned($clog2(n)) : 32'd1;
   endfunction

   // Addresses arrive zero-extended so one function serves any addr_t up to 64 bits.
   function automatic logic rule_ok(
      input int unsigned             idx,
      input logic [MaxAddrWidth-1:0] start_addr,
      input logic [MaxAddrWidth-1:0] end_addr,
      input int unsigned             no_indices,
      input logic                    napot
   );
      logic ok;
      ok = (idx < no_indices);
      if (!napot && (end_addr != {MaxAddrWidth{1'b0}}) && (start_addr >= end_addr)) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/addr_map_cfg_ctrl_chk.sv
// Protocol properties of the rule-table configuration controller.
module addr_map_cfg_ctrl_chk #(
   parameter int unsigned NoRules = 32'd0
) (
   input logic clk,
   input logic rst_n,
   input logic wr_valid,
   input logic wr_ready,
   input logic commit_valid,
   input logic commit_ready,
   input logic commit_done,
   input logic commit_err
);

   a_no_rules: assert property (@(posedge clk) NoRules >= 32'd1);

   a_wr_valid_stable: assert property (@(posedge clk) disable iff (!rst_n)
      wr_valid && !wr_ready |=> wr_valid);

   a_commit_valid_stable: assert property (@(posedge clk) disable iff (!rst_n)
      commit_valid && !commit_ready |=> commit_valid);

   a_done_err_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(commit_done && commit_err));

endmodule

// File: rtl/addr_rule_check.sv
// Combinational validator for one rule of the shadow table.
module addr_rule_check
   import addr_map_cfg_pkg::*;
#(
   parameter int unsigned NoIndices = 32'd0,
   parameter bit          Napot     = 1'b0,
   parameter type         addr_t    = default_addr_t,
   parameter type         rule_t    = default_rule_t
) (
   input  rule_t rule,
   output logic  ok
);

   assign ok = rule_ok(rule.idx,
                       MaxAddrWidth'(rule.start_addr),
                       MaxAddrWidth'(rule.end_addr),
                       NoIndices,
                       Napot);

endmodule

// File: rtl/addr_map_cfg_ctrl.sv
// Runtime controller for the address decoder rule table: shadow writes,
// validated commit, drain handshake and single-cycle swap into the active table.
module addr_map_cfg_ctrl
   import addr_map_cfg_pkg::*;
#(
   parameter int unsigned          NoIndices  = 32'd0,
   parameter int unsigned          NoRules    = 32'd0,
   parameter type                  addr_t     = default_addr_t,
   parameter type                  rule_t     = default_rule_t,
   parameter bit                   Napot      = 1'b0,
   parameter rule_t [NoRules-1:0]  DefaultMap = '0,
   parameter int unsigned          SelWidth   = idx_width(NoRules)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     wr_valid_i,
   output logic                     wr_ready_o,
   input  logic [SelWidth-1:0]      wr_sel_i,
   input  rule_t                    wr_rule_i,
   input  logic                     commit_valid_i,
   output logic                     commit_ready_o,
   output logic                     commit_done_o,
   output logic                     commit_err_o,
   output logic [SelWidth-1:0]      err_sel_o,
   output logic                     drain_req_o,
   input  logic                     drain_ack_i,
   output logic                     config_ongoing_o,
   output rule_t [NoRules-1:0]      addr_map_o
);

   state_e               state_r;
   rule_t [NoRules-1:0]  shadow_r;
   rule_t [NoRules-1:0]  active_r;
   logic [SelWidth-1:0]  cnt_r;
   logic [SelWidth-1:0]  err_sel_r;
   logic                 fail_r;
   logic                 done_r;
   logic                 err_r;
   logic                 drain_r;
   logic                 ongoing_r;
   logic                 wr_ready_r;

   logic                 wr_fire_s;
   logic                 wr_in_range_s;
   logic                 commit_fire_s;
   logic                 last_slot_s;
   logic                 slot_ok_s;
   rule_t                slot_rule_s;

   assign wr_fire_s     = wr_valid_i & wr_ready_r;
   assign wr_in_range_s = (32'(wr_sel_i) < NoRules);
   // A pending write always wins over a same-cycle commit.
   assign commit_fire_s = commit_valid_i & wr_ready_r & ~wr_valid_i;
   assign last_slot_s   = (cnt_r == SelWidth'(NoRules - 32'd1));
   assign slot_rule_s   = shadow_r[cnt_r];

   addr_rule_check #(
      .NoIndices (NoIndices),
      .Napot     (Napot),
      .addr_t    (addr_t),
      .rule_t    (rule_t)
   ) u_rule_check (
      .rule (slot_rule_s),
      .ok   (slot_ok_s)
   );

   // Commit sequencing: scan, drain, swap; all status outputs registered here.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         err_sel_r  <= '0;
         fail_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         drain_r    <= 1'b0;
         ongoing_r  <= 1'b0;
         wr_ready_r <= 1'b1;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (commit_fire_s) begin
                  state_r    <= CHECK;
                  cnt_r      <= '0;
                  fail_r     <= 1'b0;
                  err_sel_r  <= '0;
                  wr_ready_r <= 1'b0;
               end
            end
            CHECK: begin
               if (!slot_ok_s && !fail_r) begin
                  fail_r    <= 1'b1;
                  err_sel_r <= cnt_r;
               end
               if (last_slot_s) begin
                  if (fail_r || !slot_ok_s) begin
                     state_r    <= IDLE;
                     err_r      <= 1'b1;
                     wr_ready_r <= 1'b1;
                  end else begin
                     state_r   <= QUIESCE;
                     drain_r   <= 1'b1;
                     ongoing_r <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r + SelWidth'(1);
               end
            end
            QUIESCE: begin
               if (drain_ack_i) begin
                  state_r <= SWAP;
                  drain_r <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            SWAP: begin
               state_r    <= IDLE;
               ongoing_r  <= 1'b0;
               wr_ready_r <= 1'b1;
            end
            default: begin
               state_r    <= IDLE;
               drain_r    <= 1'b0;
               ongoing_r  <= 1'b0;
               wr_ready_r <= 1'b1;
            end
         endcase
      end
   end

   // Shadow and active rule tables.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_r <= DefaultMap;
         active_r <= DefaultMap;
      end else begin
         if (wr_fire_s && wr_in_range_s) begin
            shadow_r[wr_sel_i] <= wr_rule_i;
         end
         if (state_r == SWAP) begin
            active_r <= shadow_r;
         end
      end
   end

   assign wr_ready_o       = wr_ready_r;
   assign commit_ready_o   = wr_ready_r & ~wr_valid_i;
   assign commit_done_o    = done_r;
   assign commit_err_o     = err_r;
   assign err_sel_o        = err_sel_r;
   assign drain_req_o      = drain_r;
   assign config_ongoing_o = ongoing_r;
   assign addr_map_o       = active_r;

   addr_map_cfg_ctrl_chk #(
      .NoRules (NoRules)
   ) u_chk (
      .clk          (clk_i),
      .rst_n        (rst_ni),
      .wr_valid     (wr_valid_i),
      .wr_ready     (wr_ready_o),
      .commit_valid (commit_valid_i),
      .commit_ready (commit_ready_o),
      .commit_done  (commit_done_o),
      .commit_err   (commit_err_o)
   );

endmodule

// File: tb/tb_addr_map_cfg_ctrl.sv
// Self-checking bench for addr_map_cfg_ctrl: directed scenarios plus randomized
// commits scored against a table-level reference model.
module tb_addr_map_cfg_ctrl;
   import addr_map_cfg_pkg::*;

   localparam int unsigned NR = 4;
   localparam int unsigned NI = 3;

   typedef logic [31:0] addr_t;
   typedef struct packed {
      int unsigned idx;
      addr_t       start_addr;
      addr_t       end_addr;
   } rule_t;
   typedef rule_t [NR-1:0] map_t;

   localparam map_t DEF_MAP = {32'd0, 32'h0003_0000, 32'h0003_8000,
                               32'd2, 32'h0002_0000, 32'h0002_8000,
                               32'd1, 32'h0001_0000, 32'h0001_8000,
                               32'd0, 32'h0000_0000, 32'h0000_8000};

   logic clk, rst_n;
   logic wr_valid, wr_ready, commit_valid, commit_ready, commit_done, commit_err;
   logic drain_req, drain_ack, config_ongoing;
   logic [1:0] wr_sel, err_sel;
   rule_t wr_rule;
   map_t addr_map;

   logic n_wr_valid, n_wr_ready, n_commit_valid, n_commit_ready, n_commit_done, n_commit_err;
   logic n_drain_req, n_config_ongoing;
   logic [1:0] n_wr_sel, n_err_sel;
   rule_t n_wr_rule;
   map_t n_addr_map;

   int n_cmp = 0;
   int n_fail = 0;

   map_t m_shadow, m_active;

   bit   tr_done [64];
   bit   tr_err  [64];
   bit   tr_ong  [64];
   bit   tr_drain[64];
   bit   tr_wrrdy[64];
   map_t tr_map  [64];

   addr_map_cfg_ctrl #(.NoIndices(NI), .NoRules(NR), .addr_t(addr_t), .rule_t(rule_t),
                       .Napot(1'b0), .DefaultMap(DEF_MAP)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_sel_i(wr_sel), .wr_rule_i(wr_rule),
      .commit_valid_i(commit_valid), .commit_ready_o(commit_ready),
      .commit_done_o(commit_done), .commit_err_o(commit_err), .err_sel_o(err_sel),
      .drain_req_o(drain_req), .drain_ack_i(drain_ack),
      .config_ongoing_o(config_ongoing), .addr_map_o(addr_map));

   addr_map_cfg_ctrl #(.NoIndices(NI), .NoRules(NR), .addr_t(addr_t), .rule_t(rule_t),
                       .Napot(1'b1), .DefaultMap(DEF_MAP)) dut_napot (
      .clk_i(clk), .rst_ni(rst_n),
      .wr_valid_i(n_wr_valid), .wr_ready_o(n_wr_ready), .wr_sel_i(n_wr_sel), .wr_rule_i(n_wr_rule),
      .commit_valid_i(n_commit_valid), .commit_ready_o(n_commit_ready),
      .commit_done_o(n_commit_done), .commit_err_o(n_commit_err), .err_sel_o(n_err_sel),
      .drain_req_o(n_drain_req), .drain_ack_i(1'b1),
      .config_ongoing_o(n_config_ongoing), .addr_map_o(n_addr_map));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic bit model_ok(input rule_t r, input bit napot);
      if (r.idx >= NI) return 1'b0;
      if (!napot && r.end_addr != 32'h0 && r.start_addr >= r.end_addr) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int first_fail(input map_t m, input bit napot);
      for (int s = 0; s < NR; s++) if (!model_ok(m[s], napot)) return s;
      return -1;
   endfunction

   // Scan takes NR cycles, quiesce lasts until the ack is seen, swap pulse follows.
   function automatic int exp_done_cycle(input int ack_at);
      return NR + 2 + ((ack_at > NR + 1) ? ack_at - (NR + 1) : 0);
   endfunction

   function automatic rule_t rand_rule(input bit bad);
      rule_t r;
      r.start_addr = $urandom_range(32'h0000_1000, 32'h7FFF_FFFF);
      if (!bad) begin
         r.idx      = $urandom_range(0, NI - 1);
         r.end_addr = ($urandom_range(0, 3) == 0) ? 32'h0 : r.start_addr + $urandom_range(1, 4096);
      end else if ($urandom_range(0, 1) == 0) begin
         r.idx      = $urandom_range(NI, NI + 5);
         r.end_addr = r.start_addr + 32'd100;
      end else begin
         r.idx      = $urandom_range(0, NI - 1);
         r.end_addr = r.start_addr - $urandom_range(0, 100);
      end
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [1:0] sel, input rule_t r);
      bit hs;
      hs = 1'b0;
      wr_valid = 1'b1; wr_sel = sel; wr_rule = r;
      for (int w = 0; w < 40 && !hs; w++) begin
         #1;
         hs = wr_ready;
         step();
      end
      wr_valid = 1'b0;
      if (hs) m_shadow[sel] = r;
      else begin
         n_cmp++; n_fail++;
         $display("FAIL write_timeout: wr_ready stayed 0, expected 1 within 40 cycles");
      end
   endtask

   task automatic commit_trace(input int n, input int ack_at, output bit hs);
      hs = 1'b0;
      commit_valid = 1'b1;
      for (int w = 0; w < 40 && !hs; w++) begin
         #1;
         hs = commit_ready;
         step();
      end
      commit_valid = 1'b0;
      if (!hs) begin
         n_cmp++; n_fail++;
         $display("FAIL commit_timeout: commit_ready stayed 0, expected 1 within 40 cycles");
      end else begin
         for (int k = 1; k <= n; k++) begin
            tr_done[k] = commit_done; tr_err[k] = commit_err; tr_ong[k] = config_ongoing;
            tr_drain[k] = drain_req; tr_wrrdy[k] = wr_ready; tr_map[k] = addr_map;
            drain_ack = (k >= ack_at);
            step();
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      step(); step();
      n_cmp++;
      if (addr_map !== DEF_MAP || config_ongoing !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_held: map %h ongoing %b, expected %h 0", addr_map, config_ongoing, DEF_MAP);
      end
      rst_n = 1'b1;
      m_shadow = DEF_MAP; m_active = DEF_MAP;
      step();
      n_cmp++;
      if (addr_map !== DEF_MAP) begin
         n_fail++; $display("FAIL reset_map: got %h expected %h", addr_map, DEF_MAP);
      end
      n_cmp++;
      if ({wr_ready, commit_ready, config_ongoing, commit_done, commit_err, drain_req} !== 6'b110000) begin
         n_fail++;
         $display("FAIL reset_flags: rdy/crdy/ong/done/err/drain got %b%b%b%b%b%b expected 110000",
                  wr_ready, commit_ready, config_ongoing, commit_done, commit_err, drain_req);
      end
      n_cmp++;
      if (err_sel !== 2'd0) begin
         n_fail++; $display("FAIL reset_err_sel: got %0d expected 0", err_sel);
      end
   endtask

   task automatic test_commit_ok;
      bit hs; int d, ong_cnt; map_t old_map;
      bit [3:0] got, exp;
      drain_ack = 1'b1;
      do_write(2'd0, rule_t'{idx: 32'd1, start_addr: 32'h1000, end_addr: 32'h2000});
      d = exp_done_cycle(0);
      old_map = m_active;
      commit_trace(NR + 6, 0, hs);
      if (hs) begin
         ong_cnt = 0;
         for (int k = 1; k <= NR + 6; k++) begin
            got = {tr_done[k], tr_err[k], tr_ong[k], tr_drain[k]};
            exp = {k == d, 1'b0, (k >= NR + 1 && k <= d), (k >= NR + 1 && k < d)};
            ong_cnt += int'(tr_ong[k]);
            n_cmp++;
            if (got !== exp || tr_map[k] !== ((k <= d) ? old_map : m_shadow)) begin
               n_fail++;
               $display("FAIL commit_ok_t%0d: done/err/ong/drain %b map %h, expected %b map %h",
                        k, got, tr_map[k], exp, (k <= d) ? old_map : m_shadow);
            end
         end
         n_cmp++;
         if (ong_cnt != 2) begin
            n_fail++; $display("FAIL commit_ok_ongoing_len: got %0d cycles expected 2", ong_cnt);
         end
         m_active = m_shadow;
      end
   endtask

   task automatic test_commit_err;
      bit hs; int ff;
      bit [3:0] got, exp;
      do_write(2'd2, rule_t'{idx: 32'd3, start_addr: 32'h0, end_addr: 32'h100});
      do_write(2'd3, rule_t'{idx: 32'd0, start_addr: 32'h500, end_addr: 32'h400});
      ff = first_fail(m_shadow, 1'b0);
      commit_trace(NR + 4, 0, hs);
      if (hs) begin
         for (int k = 1; k <= NR + 4; k++) begin
            got = {tr_done[k], tr_err[k], tr_ong[k], tr_drain[k]};
            exp = {1'b0, k == NR + 1, 1'b0, 1'b0};
            n_cmp++;
            if (got !== exp || tr_map[k] !== m_active) begin
               n_fail++;
               $display("FAIL commit_err_t%0d: done/err/ong/drain %b map %h, expected %b map %h",
                        k, got, tr_map[k], exp, m_active);
            end
         end
         n_cmp++;
         if (int'(err_sel) != ff) begin
            n_fail++; $display("FAIL commit_err_sel: got %0d expected %0d", err_sel, ff);
         end
      end
      do_write(2'd2, rule_t'{idx: 32'd2, start_addr: 32'h0, end_addr: 32'h100});
      do_write(2'd3, rule_t'{idx: 32'd0, start_addr: 32'h400, end_addr: 32'h500});
      n_cmp++;
      if (int'(err_sel) != ff) begin
         n_fail++; $display("FAIL err_sel_held: got %0d expected %0d", err_sel, ff);
      end
   endtask

   task automatic test_drain_stall;
      bit hs; int d, ack_at; map_t old_map;
      bit [4:0] got, exp;
      do_write(2'd1, rand_rule(1'b0));
      ack_at = NR + 1 + 10;
      d = exp_done_cycle(ack_at);
      old_map = m_active;
      commit_trace(d + 3, ack_at, hs);
      if (hs) begin
         for (int k = 1; k <= d + 3; k++) begin
            got = {tr_done[k], tr_err[k], tr_ong[k], tr_drain[k], tr_wrrdy[k]};
            exp = {k == d, 1'b0, (k >= NR + 1 && k <= d), (k >= NR + 1 && k < d), k > d};
            n_cmp++;
            if (got !== exp || tr_map[k] !== ((k <= d) ? old_map : m_shadow)) begin
               n_fail++;
               $display("FAIL stall_t%0d: done/err/ong/drain/wrrdy %b map %h, expected %b map %h",
                        k, got, tr_map[k], exp, (k <= d) ? old_map : m_shadow);
            end
         end
         m_active = m_shadow;
      end
      drain_ack = 1'b1;
   endtask

   task automatic test_back_to_back;
      bit hs; int d; rule_t r;
      r = rule_t'{idx: 32'd2, start_addr: 32'h7000, end_addr: 32'h7800};
      wr_valid = 1'b1; wr_sel = 2'd3; wr_rule = r; commit_valid = 1'b1;
      #1;
      n_cmp++;
      if (commit_ready !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_priority: commit_ready %b wr_ready %b, expected 0 1", commit_ready, wr_ready);
      end
      step();
      wr_valid = 1'b0;
      m_shadow[3] = r;
      #1;
      n_cmp++;
      if (commit_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_commit_ready: got %b expected 1", commit_ready);
      end
      d = exp_done_cycle(0);
      commit_trace(d + 1, 0, hs);
      if (hs) begin
         n_cmp++;
         if (tr_done[d] !== 1'b1 || tr_map[d + 1] !== m_shadow) begin
            n_fail++;
            $display("FAIL b2b_swap: done %b map %h, expected 1 map %h", tr_done[d], tr_map[d + 1], m_shadow);
         end
         m_active = m_shadow;
      end
   endtask

   task automatic test_random;
      bit hs; int nw, ack_at, ff, d; map_t old_map, exp_map;
      bit [1:0] got, exp;
      for (int it = 0; it < 12; it++) begin
         nw = $urandom_range(1, 3);
         for (int j = 0; j < nw; j++)
            do_write(2'($urandom_range(0, NR - 1)), rand_rule($urandom_range(0, 3) == 0));
         if (it % 2 == 0)
            for (int s = 0; s < NR; s++)
               if (!model_ok(m_shadow[s], 1'b0)) do_write(2'(s), rand_rule(1'b0));
         ack_at = $urandom_range(0, 9);
         ff = first_fail(m_shadow, 1'b0);
         d = exp_done_cycle(ack_at);
         old_map = m_active;
         commit_trace(d + 1, ack_at, hs);
         if (hs) begin
            for (int k = 1; k <= d + 1; k++) begin
               got = {tr_done[k], tr_err[k]};
               exp = (ff < 0) ? {k == d, 1'b0} : {1'b0, k == NR + 1};
               exp_map = (ff < 0 && k > d) ? m_shadow : old_map;
               n_cmp++;
               if (got !== exp || tr_map[k] !== exp_map) begin
                  n_fail++;
                  $display("FAIL rand%0d_t%0d: done/err %b map %h, expected %b map %h",
                           it, k, got, tr_map[k], exp, exp_map);
               end
            end
            if (ff < 0) m_active = m_shadow;
            else begin
               n_cmp++;
               if (int'(err_sel) != ff) begin
                  n_fail++; $display("FAIL rand%0d_err_sel: got %0d expected %0d", it, err_sel, ff);
               end
            end
         end
      end
      drain_ack = 1'b1;
   endtask

   task automatic test_reset_quiesce;
      bit hs; int d;
      do_write(2'd0, rule_t'{idx: 32'd2, start_addr: 32'hA000, end_addr: 32'hB000});
      commit_trace(NR + 3, 100, hs);
      if (hs) begin
         n_cmp++;
         if (drain_req !== 1'b1 || config_ongoing !== 1'b1) begin
            n_fail++;
            $display("FAIL quiesce_held: drain %b ong %b, expected 1 1", drain_req, config_ongoing);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      m_shadow = DEF_MAP; m_active = DEF_MAP;
      n_cmp++;
      if (addr_map !== DEF_MAP || config_ongoing !== 1'b0 || drain_req !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: map %h ong %b drain %b rdy %b, expected %h 0 0 1",
                  addr_map, config_ongoing, drain_req, wr_ready, DEF_MAP);
      end
      drain_ack = 1'b1;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         n_cmp++;
         if (commit_done !== 1'b0 || addr_map !== DEF_MAP) begin
            n_fail++;
            $display("FAIL post_reset_%0d: done %b map %h, expected 0 map %h", k, commit_done, addr_map, DEF_MAP);
         end
         step();
      end
      d = exp_done_cycle(0);
      commit_trace(d + 1, 0, hs);
      if (hs) begin
         n_cmp++;
         if (tr_done[d] !== 1'b1 || tr_map[d + 1] !== DEF_MAP) begin
            n_fail++;
            $display("FAIL shadow_after_reset: done %b map %h, expected 1 map %h", tr_done[d], tr_map[d + 1], DEF_MAP);
         end
      end
   endtask

   task automatic test_napot;
      bit hs, err_seen; int done_k; rule_t r; map_t exp_map, map_before, map_after;
      r = rule_t'{idx: 32'd1, start_addr: 32'h500, end_addr: 32'h400};
      exp_map = DEF_MAP; exp_map[1] = r;
      n_wr_valid = 1'b1; n_wr_sel = 2'd1; n_wr_rule = r;
      hs = 1'b0;
      for (int w = 0; w < 20 && !hs; w++) begin #1; hs = n_wr_ready; step(); end
      n_wr_valid = 1'b0;
      n_commit_valid = 1'b1;
      hs = 1'b0;
      for (int w = 0; w < 20 && !hs; w++) begin #1; hs = n_commit_ready; step(); end
      n_commit_valid = 1'b0;
      done_k = -1; err_seen = 1'b0;
      map_before = '0; map_after = '0;
      for (int k = 1; k <= NR + 6; k++) begin
         if (n_commit_done && done_k < 0) done_k = k;
         err_seen |= n_commit_err;
         if (k == NR + 2) map_before = n_addr_map;
         if (k == NR + 3) map_after = n_addr_map;
         step();
      end
      n_cmp++;
      if (done_k != NR + 2 || err_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL napot_commit: done at t+%0d err %b, expected t+%0d err 0", done_k, err_seen, NR + 2);
      end
      n_cmp++;
      if (map_before !== DEF_MAP || map_after !== exp_map) begin
         n_fail++;
         $display("FAIL napot_map: before %h after %h, expected %h then %h", map_before, map_after, DEF_MAP, exp_map);
      end
   endtask

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_sel = 2'd0; wr_rule = '0;
      commit_valid = 1'b0; drain_ack = 1'b1;
      n_wr_valid = 1'b0; n_wr_sel = 2'd0; n_wr_rule = '0; n_commit_valid = 1'b0;
      test_reset();
      test_commit_ok();
      test_commit_err();
      test_drain_stall();
      test_back_to_back();
      test_random();
      test_reset_quiesce();
      test_napot();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
